// File: rtl/persiana_cmd_arbiter.sv
// persiana_cmd_arbiter: fixed-priority arbiter (manual over sensor) in front
// of FSM_Persiana, plus motion supervision with a hold-off window.
// Optional watchdog: define PERSIANA_WATCHDOG_EN to enable the MOVE timeout
// and the FAULT state; without it FAULT is unreachable and fault is tied 0.
//
// state | meaning
// IDLE  | waiting for a request; last command still driven
// MOVE  | command issued, waiting for its target sensor
// HOLD  | target reached, sensor requests blocked for HOLD_TICKS
// FAULT | watchdog expired; command outputs forced off until fault_clr
module persiana_cmd_arbiter #(
  parameter int TIMEOUT_TICKS = 30,
  parameter int HOLD_TICKS    = 4
) (
  input  logic       clk,
  input  logic       reseteo,
  input  logic       tick,
  input  logic       man_req,
  input  logic [1:0] man_cmd,
  output logic       man_ack,
  input  logic       sen_req,
  input  logic [1:0] sen_cmd,
  output logic       sen_ack,
  input  logic       Ssup,
  input  logic       Smed,
  input  logic       Sinf,
  input  logic       fault_clr,
  output logic       cerrar,
  output logic       medio,
  output logic       abrir,
  output logic       automatico,
  output logic       busy,
  output logic       fault
);

  localparam int MAX_TICKS = (TIMEOUT_TICKS > HOLD_TICKS) ? TIMEOUT_TICKS : HOLD_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_TICKS);
`ifdef PERSIANA_WATCHDOG_EN
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT_TICKS);
`endif

  localparam logic [1:0] CMD_CERRAR = 2'b00;
  localparam logic [1:0] CMD_MEDIO  = 2'b01;
  localparam logic [1:0] CMD_ABRIR  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          cmd_vld_q, cmd_vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    cmd_oh_q, cmd_oh_d;
  logic          target_hit;
  logic          preempt;

  // saturating increment so the counter can never wrap
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // target sensor for the command currently in the register; automatico has none
  always_comb begin
    target_hit = 1'b1;
    case (cmd_q)
      CMD_CERRAR: target_hit = Sinf;
      CMD_MEDIO:  target_hit = Smed;
      CMD_ABRIR:  target_hit = Ssup;
      default:    target_hit = 1'b1;
    endcase
  end

  assign preempt = man_req && (man_cmd != cmd_q);

  // next-state, command register, counter and combinational grants
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cmd_vld_d = cmd_vld_q;
    cnt_d     = cnt_q;
    man_ack   = 1'b0;
    sen_ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (man_req) begin
          man_ack   = 1'b1;
          cmd_d     = man_cmd;
          cmd_vld_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_MOVE;
        end else if (sen_req) begin
          sen_ack   = 1'b1;
          cmd_d     = sen_cmd;
          cmd_vld_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_MOVE;
        end
      end
      ST_MOVE: begin
        man_ack = man_req;
        if (preempt) begin
          // sensor is re-evaluated against the new target next cycle
          cmd_d = man_cmd;
          cnt_d = '0;
        end else if (target_hit) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (tick) begin
          cnt_d = cnt_inc;
`ifdef PERSIANA_WATCHDOG_EN
          if (cnt_inc >= TIMEOUT_CNT) state_d = ST_FAULT;
`endif
        end
      end
      ST_HOLD: begin
        man_ack = man_req;
        if (preempt) begin
          cmd_d   = man_cmd;
          cnt_d   = '0;
          state_d = ST_MOVE;
        end else if (tick) begin
          if (cnt_inc >= HOLD_CNT) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
`ifdef PERSIANA_WATCHDOG_EN
        if (fault_clr) begin
          cmd_vld_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end
`else
        // unreachable without the watchdog; recover to a quiet IDLE
        cmd_vld_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
`endif
      end
    endcase
  end

  // one-hot command outputs are registered from the next command and state
  always_comb begin
    cmd_oh_d = 4'b0000;
    if (cmd_vld_d && (state_d != ST_FAULT)) cmd_oh_d = 4'b0001 << cmd_d;
  end

  // state and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      state_q   <= ST_IDLE;
      cmd_q     <= 2'b00;
      cmd_vld_q <= 1'b0;
      cnt_q     <= '0;
      cmd_oh_q  <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cmd_vld_q <= cmd_vld_d;
      cnt_q     <= cnt_d;
      cmd_oh_q  <= cmd_oh_d;
    end
  end

  assign cerrar     = cmd_oh_q[0];
  assign medio      = cmd_oh_q[1];
  assign abrir      = cmd_oh_q[2];
  assign automatico = cmd_oh_q[3];
  assign busy       = (state_q == ST_MOVE) || (state_q == ST_HOLD);

`ifdef PERSIANA_WATCHDOG_EN
  assign fault = (state_q == ST_FAULT);
`else
  logic fault_clr_unused;
  assign fault_clr_unused = fault_clr;
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_persiana_cmd_arbiter.sv
// Directed bench for persiana_cmd_arbiter. Stimulus pushes expected output
// vectors into a scoreboard; a monitor on the falling edge pops and compares.
// Vector layout: {man_ack, sen_ack, cerrar, medio, abrir, automatico, busy, fault}
module tb_persiana_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reseteo;
  logic       tick;
  logic       man_req;
  logic [1:0] man_cmd;
  logic       man_ack;
  logic       sen_req;
  logic [1:0] sen_cmd;
  logic       sen_ack;
  logic       Ssup, Smed, Sinf;
  logic       fault_clr;
  logic       cerrar, medio, abrir, automatico;
  logic       busy, fault;

  int total = 0;
  int bad   = 0;

  string      name_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] idle_vec;

  persiana_cmd_arbiter #(.TIMEOUT_TICKS(30), .HOLD_TICKS(4)) dut (
    .clk(clk), .reseteo(reseteo), .tick(tick),
    .man_req(man_req), .man_cmd(man_cmd), .man_ack(man_ack),
    .sen_req(sen_req), .sen_cmd(sen_cmd), .sen_ack(sen_ack),
    .Ssup(Ssup), .Smed(Smed), .Sinf(Sinf), .fault_clr(fault_clr),
    .cerrar(cerrar), .medio(medio), .abrir(abrir), .automatico(automatico),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // monitor: compare every pending expectation against the sampled outputs
  always @(negedge clk) begin
    logic [7:0] obs;
    logic [7:0] e;
    string      n;
    obs = {man_ack, sen_ack, cerrar, medio, abrir, automatico, busy, fault};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s got=%b want=%b (ma sa c m a au busy flt)", n, obs, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [7:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  // four ticks of HOLD, then one IDLE cycle
  task automatic hold_out(input string n, input logic [7:0] v_hold, input logic [7:0] v_idle);
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      chk({n, "_hold"}, v_hold);
      step();
    end
    tick = 1'b0;
    chk({n, "_idle"}, v_idle);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reseteo = 1'b1; tick = 1'b0;
    man_req = 1'b0; man_cmd = 2'b00; sen_req = 1'b0; sen_cmd = 2'b00;
    Ssup = 1'b0; Smed = 1'b0; Sinf = 1'b0; fault_clr = 1'b0;
    step();
    chk("reset", 8'b0000_0000);
    step();
    reseteo = 1'b0;

    // 1: manual abrir, Ssup, hold-off, IDLE keeps abrir
    man_req = 1'b1; man_cmd = 2'b10;
    chk("t1_ack", 8'b1000_0000);
    step();
    man_req = 1'b0; Ssup = 1'b1;
    chk("t1_move", 8'b0000_1010);
    step();
    Ssup = 1'b0;
    hold_out("t1", 8'b0000_1010, 8'b0000_1000);

    // 2: simultaneous requests, manual wins, sensor served after HOLD
    man_req = 1'b1; man_cmd = 2'b00; sen_req = 1'b1; sen_cmd = 2'b01;
    chk("t2_arb", 8'b1000_1000);
    step();
    man_req = 1'b0; Sinf = 1'b1;
    chk("t2_move", 8'b0010_0010);
    step();
    Sinf = 1'b0;
    hold_out("t2", 8'b0010_0010, 8'b0110_0000);
    sen_req = 1'b0; Smed = 1'b1;
    chk("t2_medio", 8'b0001_0010);
    step();
    Smed = 1'b0;
    hold_out("t2b", 8'b0001_0010, 8'b0001_0000);

    // 3: preemption in MOVE, stale sensor ignored, same-cmd ack, HOLD preemption
    man_req = 1'b1; man_cmd = 2'b00;
    chk("t3_ack", 8'b1001_0000);
    step();
    man_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      chk("t3_move", 8'b0010_0010);
      step();
    end
    tick = 1'b0; man_req = 1'b1; man_cmd = 2'b10;
    chk("t3_preempt", 8'b1010_0010);
    step();
    Sinf = 1'b1;
    chk("t3_same_cmd", 8'b1000_1010);
    step();
    man_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      chk("t3_stay_move", 8'b0000_1010);
      step();
    end
    tick = 1'b0;
    chk("t3_still_move", 8'b0000_1010);
    step();
    Sinf = 1'b0; Ssup = 1'b1;
    chk("t3_target", 8'b0000_1010);
    step();
    Ssup = 1'b0; man_req = 1'b1; man_cmd = 2'b11;
    chk("t3_hold_preempt", 8'b1000_1010);
    step();
    man_req = 1'b0;
    chk("t3_auto", 8'b0000_0110);
    step();
    hold_out("t3b", 8'b0000_0110, 8'b0000_0100);

    // 4: watchdog timeout, or no timeout when disabled
    man_req = 1'b1; man_cmd = 2'b00;
    chk("t4_ack", 8'b1000_0100);
    step();
    man_req = 1'b0;
`ifdef PERSIANA_WATCHDOG_EN
    for (int i = 0; i < 29; i++) begin
      tick = 1'b1;
      chk("t4_move", 8'b0010_0010);
      step();
    end
    tick = 1'b1;
    chk("t4_30th", 8'b0010_0010);
    step();
    tick = 1'b0; man_req = 1'b1; sen_req = 1'b1;
    chk("t4_fault", 8'b0000_0001);
    step();
    man_req = 1'b0; sen_req = 1'b0; fault_clr = 1'b1;
    chk("t4_fault_clr", 8'b0000_0001);
    step();
    fault_clr = 1'b0;
    chk("t4_cleared", 8'b0000_0000);
    step();
    idle_vec = 8'b0000_0000;
`else
    for (int i = 0; i < 100; i++) begin
      tick = 1'b1;
      chk("t4_no_timeout", 8'b0010_0010);
      step();
    end
    tick = 1'b0; Sinf = 1'b1;
    chk("t4_target", 8'b0010_0010);
    step();
    Sinf = 1'b0;
    hold_out("t4", 8'b0010_0010, 8'b0010_0000);
    idle_vec = 8'b0010_0000;
`endif

    // 5: target sensor and 30th tick on the same edge -> HOLD, no fault
    man_req = 1'b1; man_cmd = 2'b01;
    chk("t5_ack", 8'b1000_0000 | idle_vec);
    step();
    man_req = 1'b0;
    for (int i = 0; i < 29; i++) begin
      tick = 1'b1;
      chk("t5_move", 8'b0001_0010);
      step();
    end
    tick = 1'b1; Smed = 1'b1;
    chk("t5_30th", 8'b0001_0010);
    step();
    tick = 1'b0; Smed = 1'b0;
    hold_out("t5", 8'b0001_0010, 8'b0001_0000);

    // 6: asynchronous reset during HOLD
    man_req = 1'b1; man_cmd = 2'b10;
    chk("t6_ack", 8'b1001_0000);
    step();
    man_req = 1'b0; Ssup = 1'b1;
    chk("t6_move", 8'b0000_1010);
    step();
    Ssup = 1'b0;
    chk("t6_hold", 8'b0000_1010);
    step();
    reseteo = 1'b1;
    #1;
    chk("t6_async", 8'b0000_0000);
    step();
    reseteo = 1'b0;
    chk("t6_idle", 8'b0000_0000);
    step();
    man_req = 1'b1; man_cmd = 2'b11;
    chk("t6_after_ack", 8'b1000_0000);
    step();
    man_req = 1'b0;
    chk("t6_after_auto", 8'b0000_0110);
    step();

    for (int i = 0; i < 3 && exp_q.size() > 0; i++) step();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/persiana_cmd_arbiter.md
# persiana_cmd_arbiter

Command arbiter and motion supervisor that sits in front of the blind state machine (`FSM_Persiana`). It takes requests from two sources, manual switches and the light-sensor automation, and grants one of them with fixed priority. It drives the one-hot command levels `cerrar`/`medio`/`abrir`/`automatico` into the FSM, then supervises the resulting motion until the target end/position sensor is reached, a hold-off time expires, or a watchdog timeout forces a fault.

## Interface
Parameters:
- `TIMEOUT_TICKS`, default 30: maximum `tick` strobes allowed in MOVE before a fault.
- `HOLD_TICKS`, default 4: `tick` strobes in HOLD before new sensor requests are accepted.

Ports:
- `clk`  in  1  system clock
- `reseteo`  in  1  reset; **asynchronous, active-high; clock `clk`**
- `tick`  in  1  one-cycle time-base strobe (slow timebase, e.g. derived from the prescaler)
- `man_req`  in  1  manual request, held until acked
- `man_cmd`  in  2  00 cerrar, 01 medio, 10 abrir, 11 automatico
- `man_ack`  out  1  manual grant, combinational
- `sen_req`  in  1  sensor-automation request, held until acked
- `sen_cmd`  in  2  encoding as `man_cmd`
- `sen_ack`  out  1  sensor grant, combinational
- `Ssup`, `Smed`, `Sinf`  in  1 each  blind position sensors: top, middle, bottom
- `fault_clr`  in  1  clears FAULT
- `cerrar`, `medio`, `abrir`, `automatico`  out  1 each  registered one-hot command to the FSM
- `busy`  out  1  high in MOVE or HOLD
- `fault`  out  1  high in FAULT

## Operation
States: IDLE, MOVE, HOLD, FAULT. Reset enters IDLE with all outputs 0 and tick counter 0.

- **IDLE**
  - `man_req` → `man_ack`=1 in the same cycle. The command register loads `man_cmd` at the edge. Go to MOVE with counter 0.
  - Else `sen_req` → `sen_ack`=1, same load. Go to MOVE.
  - Both requests asserted → manual wins; `sen_ack`=0 and the sensor request stays pending.
- **MOVE**
  - Counter increments on each `tick`.
  - Target reached → HOLD, counter 0. Targets: cerrar→`Sinf`, medio→`Smed`, abrir→`Ssup`. automatico has no target and goes to HOLD on the next edge.
  - `man_req` with `man_cmd` ≠ current command → `man_ack`=1. The new command loads, counter resets to 0, and the state stays MOVE (preemption).
  - `man_req` with `man_cmd` equal to the current command → acked and no other effect.
  - `sen_req` is never acked in MOVE.
- **HOLD**
  - Counter increments on each `tick`. At `HOLD_TICKS` → IDLE.
  - Manual preemption works as in MOVE: new command loads and the state returns to MOVE.
  - `sen_req` is not acked.
- **FAULT**
  - Command outputs are forced to 0000, while the command register is retained.
  - `fault`=1. Both acks are 0.
  - `fault_clr` → IDLE, with command outputs 0000.
- One-hot invariant: at most one of the four command outputs is high at any time.

## Timing
- Acks are combinational from the current state and requests. Requesters must drop `req` on the edge following the ack.
- Command outputs change on the clock edge that samples the grant, so they are valid 1 cycle after the ack.
- Counter width is `$clog2(max(TIMEOUT_TICKS,HOLD_TICKS)+1)` bits. It saturates and never wraps.
- Timeout fires on the edge that samples the `TIMEOUT_TICKS`-th `tick` in MOVE.
- Target sensor and timeout on the same edge → sensor wins, go to HOLD.
- Preemption and target sensor on the same edge → preemption wins. The sensor is re-evaluated against the new target.
- `tick` is ignored outside MOVE and HOLD.
- `reseteo` mid-operation: all state and outputs return to reset values immediately and asynchronously.

## Configuration
- `PERSIANA_WATCHDOG_EN` defined:
  - MOVE timeout → FAULT as above.
  - `fault_clr` is functional.
- Not defined:
  - No timeout; MOVE exits only via target sensor or preemption.
  - FAULT state is unreachable, `fault` is tied 0, and `fault_clr` is ignored.

## Test plan
1. Reset, then `man_req`=1 with `man_cmd`=10 → `man_ack`=1 that cycle. `abrir`=1 next cycle with `busy`=1. Assert `Ssup` → HOLD. 4 ticks later → IDLE with `abrir` still 1.
2. `man_req`(00) and `sen_req`(01) in the same IDLE cycle → `man_ack`=1, `sen_ack`=0, `cerrar`=1. After HOLD ends, `sen_req` still high → `sen_ack`=1 and `medio`=1.
3. MOVE with cerrar, then `man_req`(10) → ack, `abrir`=1, counter back to 0. `Sinf` asserted afterwards → no transition.
4. Watchdog enabled: MOVE with no sensor for 30 ticks → `fault`=1 and commands 0000. `fault_clr` → IDLE with `fault`=0. Watchdog disabled: 100 ticks → still MOVE.
5. In MOVE with `Smed` and the 30th tick on the same edge (target medio) → HOLD and `fault`=0.
6. Assert `reseteo` during HOLD → all outputs 0 asynchronously. After release the FSM is in IDLE.
